// File: rtl/det_nn_ctrl.sv
// det_nn_ctrl: streams the 1257-word detector weight image into det_nn and
// arbitrates classify requests once the weights are resident.
// Optional build macro DET_NN_CTRL_CSUM_EN adds the wt_csum checksum port.
module det_nn_ctrl #(
  parameter int unsigned WORD_W      = 64,
  parameter int unsigned NUM_LAYERS  = 7,
  parameter int unsigned TOTAL_WORDS = 1257
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              wt_valid,
  input  logic [WORD_W-1:0] wt_data,
  output logic              wt_ready,
  output logic              loaded,
  input  logic              cls_req,
  output logic              cls_busy,
  output logic              res_valid,
  output logic              res,
  output logic              cls_err,
  output logic              nn_write_weight,
  output logic [2:0]        nn_layer_sel,
  output logic [3:0]        nn_neuron_sel,
  output logic [6:0]        nn_weight_sel,
  output logic [WORD_W-1:0] nn_weight_bus,
  output logic              nn_start,
  input  logic              nn_done,
  input  logic              nn_result
`ifdef DET_NN_CTRL_CSUM_EN
  ,
  output logic [WORD_W-1:0] wt_csum
`endif
);

  localparam int unsigned      CNT_W      = $clog2(TOTAL_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(TOTAL_WORDS - 1);
  localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);

  // Highest weight_sel of a layer (equals its input count, bias is 0).
  function automatic logic [6:0] layer_inputs(input logic [2:0] l);
    case (l)
      3'd0:    layer_inputs = 7'd100;
      3'd1:    layer_inputs = 7'd25;
      3'd2:    layer_inputs = 7'd80;
      3'd3:    layer_inputs = 7'd4;
      3'd4:    layer_inputs = 7'd16;
      3'd5:    layer_inputs = 7'd5;
      default: layer_inputs = 7'd3;
    endcase
  endfunction

  // Index of the last neuron in a layer.
  function automatic logic [3:0] layer_last_neuron(input logic [2:0] l);
    case (l)
      3'd0:    layer_last_neuron = 4'd3;
      3'd1:    layer_last_neuron = 4'd15;
      3'd2:    layer_last_neuron = 4'd4;
      default: layer_last_neuron = 4'd0;
    endcase
  endfunction

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_READY, ST_START, ST_WAIT} state_t;

  state_t           state;
  logic [2:0]       layer_q;
  logic [3:0]       neuron_q;
  logic [6:0]       wsel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             loaded_pend;
  logic             load_pend;
  logic             done_low;

  logic             restart_c;
  logic             accept_c;
  logic             start_load_c;
  logic             last_word_c;
  logic [2:0]       idx_l, nxt_l;
  logic [3:0]       idx_n, nxt_n;
  logic [6:0]       idx_w, nxt_w;
  logic [CNT_W-1:0] idx_cnt;

  assign wt_ready = (state == ST_LOAD);

  // Current write index (a restart in LOAD rewinds it) and its successor.
  always_comb begin
    restart_c    = (state == ST_LOAD) && load_req;
    accept_c     = (state == ST_LOAD) && wt_valid;
    start_load_c = ((state == ST_IDLE) && load_req) ||
                   ((state == ST_READY) && (load_req || load_pend));
    idx_l   = restart_c ? 3'd0 : layer_q;
    idx_n   = restart_c ? 4'd0 : neuron_q;
    idx_w   = restart_c ? 7'd0 : wsel_q;
    idx_cnt = restart_c ? '0 : cnt_q;
    nxt_l   = idx_l;
    nxt_n   = idx_n;
    nxt_w   = idx_w + 7'd1;
    if (idx_w == layer_inputs(idx_l)) begin
      nxt_w = 7'd0;
      if (idx_n == layer_last_neuron(idx_l)) begin
        nxt_n = 4'd0;
        nxt_l = (idx_l == LAST_LAYER) ? 3'd0 : idx_l + 3'd1;
      end else begin
        nxt_n = idx_n + 4'd1;
      end
    end
    last_word_c = (idx_cnt == LAST_WORD);
  end

  // Sequencer FSM with registered det_nn and host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      layer_q         <= 3'd0;
      neuron_q        <= 4'd0;
      wsel_q          <= 7'd0;
      cnt_q           <= '0;
      loaded_pend     <= 1'b0;
      load_pend       <= 1'b0;
      done_low        <= 1'b0;
      loaded          <= 1'b0;
      cls_busy        <= 1'b0;
      res_valid       <= 1'b0;
      res             <= 1'b0;
      cls_err         <= 1'b0;
      nn_write_weight <= 1'b0;
      nn_layer_sel    <= 3'd0;
      nn_neuron_sel   <= 4'd0;
      nn_weight_sel   <= 7'd0;
      nn_weight_bus   <= '0;
      nn_start        <= 1'b0;
    end else begin
      nn_write_weight <= 1'b0;
      nn_start        <= 1'b0;
      res_valid       <= 1'b0;
      cls_err         <= 1'b0;
      // loaded rises one cycle after the final weight write
      if (loaded_pend) begin
        loaded      <= 1'b1;
        loaded_pend <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (cls_req) cls_err <= 1'b1;
        end
        ST_LOAD: begin
          if (cls_req) cls_err <= 1'b1;
          if (accept_c) begin
            nn_write_weight <= 1'b1;
            nn_weight_bus   <= wt_data;
            nn_layer_sel    <= idx_l;
            nn_neuron_sel   <= idx_n;
            nn_weight_sel   <= idx_w;
            layer_q         <= nxt_l;
            neuron_q        <= nxt_n;
            wsel_q          <= nxt_w;
            cnt_q           <= idx_cnt + CNT_W'(1);
            if (last_word_c) begin
              state       <= ST_READY;
              loaded_pend <= 1'b1;
            end
          end else if (restart_c) begin
            layer_q  <= 3'd0;
            neuron_q <= 4'd0;
            wsel_q   <= 7'd0;
            cnt_q    <= '0;
          end
        end
        ST_READY: begin
          if (cls_req) begin
            if (load_req || load_pend) begin
              cls_err <= 1'b1;
            end else begin
              state    <= ST_START;
              nn_start <= 1'b1;
              cls_busy <= 1'b1;
            end
          end
        end
        ST_START: begin
          if (cls_req)  cls_err   <= 1'b1;
          if (load_req) load_pend <= 1'b1;
          done_low <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cls_req)  cls_err   <= 1'b1;
          if (load_req) load_pend <= 1'b1;
          // only a done that follows a low sample completes the request
          if (nn_done && done_low) begin
            res       <= nn_result;
            res_valid <= 1'b1;
            cls_busy  <= 1'b0;
            state     <= ST_READY;
          end else if (!nn_done) begin
            done_low <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (start_load_c) begin
        state       <= ST_LOAD;
        layer_q     <= 3'd0;
        neuron_q    <= 4'd0;
        wsel_q      <= 7'd0;
        cnt_q       <= '0;
        loaded      <= 1'b0;
        loaded_pend <= 1'b0;
        load_pend   <= 1'b0;
      end
    end
  end

`ifdef DET_NN_CTRL_CSUM_EN
  // Running sum of words accepted in the current load; static outside LOAD.
  always_ff @(posedge clk) begin
    if (rst || start_load_c) begin
      wt_csum <= '0;
    end else if (accept_c) begin
      wt_csum <= (restart_c ? '0 : wt_csum) + wt_data;
    end else if (restart_c) begin
      wt_csum <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_det_nn_ctrl.sv
// Self-checking bench for det_nn_ctrl with a small det_nn responder model.
// Build with DET_NN_CTRL_CSUM_EN to also check wt_csum.
module tb_det_nn_ctrl;

  localparam int unsigned WORD_W = 64;
  localparam int          NWORDS = 1257;

  logic              clk;
  logic              rst;
  logic              load_req;
  logic              wt_valid;
  logic [WORD_W-1:0] wt_data;
  logic              wt_ready;
  logic              loaded;
  logic              cls_req;
  logic              cls_busy;
  logic              res_valid;
  logic              res;
  logic              cls_err;
  logic              nn_write_weight;
  logic [2:0]        nn_layer_sel;
  logic [3:0]        nn_neuron_sel;
  logic [6:0]        nn_weight_sel;
  logic [WORD_W-1:0] nn_weight_bus;
  logic              nn_start;
  logic              nn_done;
  logic              nn_result;
`ifdef DET_NN_CTRL_CSUM_EN
  logic [WORD_W-1:0] wt_csum;
`endif

  det_nn_ctrl dut (
    .clk(clk), .rst(rst), .load_req(load_req), .wt_valid(wt_valid),
    .wt_data(wt_data), .wt_ready(wt_ready), .loaded(loaded), .cls_req(cls_req),
    .cls_busy(cls_busy), .res_valid(res_valid), .res(res), .cls_err(cls_err),
    .nn_write_weight(nn_write_weight), .nn_layer_sel(nn_layer_sel),
    .nn_neuron_sel(nn_neuron_sel), .nn_weight_sel(nn_weight_sel),
    .nn_weight_bus(nn_weight_bus), .nn_start(nn_start), .nn_done(nn_done),
    .nn_result(nn_result)
`ifdef DET_NN_CTRL_CSUM_EN
    , .wt_csum(wt_csum)
`endif
  );

  typedef struct packed {
    logic [2:0]        l;
    logic [3:0]        n;
    logic [6:0]        w;
    logic [WORD_W-1:0] d;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;
  int nn_neurons [7] = '{4, 16, 5, 1, 1, 1, 1};
  int nn_inputs  [7] = '{100, 25, 80, 4, 16, 5, 3};

  wr_t               got[$];
  logic [WORD_W-1:0] sent[$];
  wr_t               mon_w;
  int                overlap = 0;

  int m_delay   = 1;
  bit m_result  = 1'b0;
  bit m_preheld = 1'b0;
  bit done_raised = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Capture every weight write and any start/write overlap.
  always @(negedge clk) begin
    if (nn_write_weight) begin
      mon_w.l = nn_layer_sel;
      mon_w.n = nn_neuron_sel;
      mon_w.w = nn_weight_sel;
      mon_w.d = nn_weight_bus;
      got.push_back(mon_w);
    end
    if (nn_write_weight && nn_start) overlap++;
  end

  // det_nn stand-in: answers each start after m_delay cycles.
  initial begin
    nn_done   = 1'b0;
    nn_result = 1'b0;
    forever begin
      @(negedge clk);
      if (nn_start) begin
        if (m_preheld) begin
          repeat (3) @(posedge clk);
          #1 nn_done = 1'b0;
        end
        repeat (m_delay) @(posedge clk);
        #1;
        nn_result   = m_result;
        nn_done     = 1'b1;
        done_raised = 1'b1;
        @(posedge clk);
        #1 nn_done = 1'b0;
      end
    end
  end

  task automatic pulse_load();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic pulse_cls();
    @(posedge clk); #1 cls_req = 1'b1;
    @(posedge clk); #1 cls_req = 1'b0;
  endtask

  // Offer n words; mode 0 = no stalls, 1 = idle every third cycle, 2 = random idles.
  task automatic stream_words(input int n, input int mode, input bit rand_data, output bit ok);
    int i   = 0;
    int cyc = 0;
    while (i < n && cyc < 2 * n + 50) begin
      @(posedge clk); #1;
      if (mode == 1)      wt_valid = (cyc % 3) != 2;
      else if (mode == 2) wt_valid = $urandom_range(0, 3) != 0;
      else                wt_valid = 1'b1;
      wt_data = rand_data ? {$urandom, $urandom} : WORD_W'(sent.size());
      @(negedge clk);
      if (wt_valid && wt_ready) begin
        sent.push_back(wt_data);
        i++;
      end
      cyc++;
    end
    @(posedge clk); #1 wt_valid = 1'b0;
    ok = (i == n);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; load_req = 1'b0; cls_req = 1'b0; wt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({loaded, wt_ready, cls_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: loaded/ready/busy=%b want 000", {loaded, wt_ready, cls_busy});
    end
    n_tests++;
    if ({res_valid, res, cls_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_result: res_valid/res/cls_err=%b want 000", {res_valid, res, cls_err});
    end
    n_tests++;
    if ({nn_write_weight, nn_start, nn_layer_sel, nn_neuron_sel, nn_weight_sel} !== 16'd0) begin
      n_fail++; $display("FAIL reset_nn_ctrl: we=%b st=%b sel=%0d/%0d/%0d want all 0",
                         nn_write_weight, nn_start, nn_layer_sel, nn_neuron_sel, nn_weight_sel);
    end
    n_tests++;
    if (nn_weight_bus !== '0) begin
      n_fail++; $display("FAIL reset_bus: got %0h want 0", nn_weight_bus);
    end
`ifdef DET_NN_CTRL_CSUM_EN
    n_tests++;
    if (wt_csum !== '0) begin
      n_fail++; $display("FAIL reset_csum: got %0h want 0", wt_csum);
    end
`endif
  endtask

  // Full load with write-sequence, loaded-timing and checksum checks.
  task automatic test_load(input int mode, input bit rand_data);
    bit ok;
    int k = 0;
    int bad = 0;
    int first_bad = -1;
    wr_t e;
    wr_t e_bad;
    wr_t g_bad;
    logic [WORD_W-1:0] sum = '0;
    sent.delete();
    pulse_load();
    got.delete();
    stream_words(NWORDS, mode, rand_data, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL load_stream: only %0d of %0d words accepted", sent.size(), NWORDS);
    end
    @(negedge clk);
    n_tests++;
    if ({nn_write_weight, loaded} !== 2'b10) begin
      n_fail++; $display("FAIL loaded_early: write/loaded=%b want 10", {nn_write_weight, loaded});
    end
    @(negedge clk);
    n_tests++;
    if ({loaded, wt_ready} !== 2'b10) begin
      n_fail++; $display("FAIL loaded_final: loaded/ready=%b want 10", {loaded, wt_ready});
    end
    n_tests++;
    if (got.size() != NWORDS) begin
      n_fail++; $display("FAIL write_count: got %0d writes want %0d", got.size(), NWORDS);
    end
    for (int l = 0; l < 7; l++)
      for (int n = 0; n < nn_neurons[l]; n++)
        for (int w = 0; w <= nn_inputs[l]; w++) begin
          if (k < got.size() && k < sent.size()) begin
            e.l = 3'(l); e.n = 4'(n); e.w = 7'(w); e.d = sent[k];
            if (got[k] !== e) begin
              if (first_bad < 0) begin first_bad = k; e_bad = e; g_bad = got[k]; end
              bad++;
            end
          end
          k++;
        end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL write_seq: %0d bad, first #%0d got (%0d,%0d,%0d,%0h) want (%0d,%0d,%0d,%0h)",
                         bad, first_bad, g_bad.l, g_bad.n, g_bad.w, g_bad.d, e_bad.l, e_bad.n, e_bad.w, e_bad.d);
    end
    if (!rand_data && got.size() == NWORDS) begin
      int   sp_i [5] = '{0, 101, 403, 404, 1256};
      wr_t  sp_e [5];
      sp_e[0] = {3'd0, 4'd0, 7'd0,   64'd0};
      sp_e[1] = {3'd0, 4'd1, 7'd0,   64'd101};
      sp_e[2] = {3'd0, 4'd3, 7'd100, 64'd403};
      sp_e[3] = {3'd1, 4'd0, 7'd0,   64'd404};
      sp_e[4] = {3'd6, 4'd0, 7'd3,   64'd1256};
      for (int s = 0; s < 5; s++) begin
        n_tests++;
        if (got[sp_i[s]] !== sp_e[s]) begin
          n_fail++; $display("FAIL write_%0d: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", sp_i[s],
                             got[sp_i[s]].l, got[sp_i[s]].n, got[sp_i[s]].w, got[sp_i[s]].d,
                             sp_e[s].l, sp_e[s].n, sp_e[s].w, sp_e[s].d);
        end
      end
    end
    foreach (sent[i]) sum = sum + sent[i];
`ifdef DET_NN_CTRL_CSUM_EN
    n_tests++;
    if (wt_csum !== sum) begin
      n_fail++; $display("FAIL csum: got %0h want %0h", wt_csum, sum);
    end
    if (!rand_data) begin
      n_tests++;
      if (wt_csum !== 64'd789396) begin
        n_fail++; $display("FAIL csum_index: got %0d want 789396", wt_csum);
      end
    end
`endif
  endtask

  task automatic test_load_index();
    test_load(0, 1'b0);
  endtask

  task automatic test_load_stall();
    test_load(1, 1'b1);
  endtask

  // One classify round trip against the det_nn model.
  task automatic test_classify(input int delay, input bit result, input bit preheld);
    int starts = 0;
    int busy_bad = 0;
    bit got_res = 1'b0;
    bit res_seen = 1'b0;
    bit busy_at = 1'b1;
    bit early = 1'b0;
    m_delay = delay; m_result = result; m_preheld = preheld; done_raised = 1'b0;
    if (preheld) begin
      @(posedge clk); #1 nn_done = 1'b1; nn_result = ~result;
    end
    pulse_cls();
    for (int cyc = 0; cyc < 300 && !got_res; cyc++) begin
      @(negedge clk);
      if (nn_start) starts++;
      if (res_valid) begin
        got_res = 1'b1; res_seen = res; busy_at = cls_busy; early = !done_raised;
      end else if (!cls_busy) begin
        busy_bad++;
      end
    end
    n_tests++;
    if (!got_res) begin
      n_fail++; $display("FAIL cls_timeout: res_valid=0 want 1 within 300 cycles");
    end
    n_tests++;
    if (starts != 1) begin
      n_fail++; $display("FAIL cls_start: nn_start high %0d cycles want 1", starts);
    end
    n_tests++;
    if (busy_bad != 0 || busy_at !== 1'b0) begin
      n_fail++; $display("FAIL cls_busy: %0d low cycles in flight, at result %b, want 0/0", busy_bad, busy_at);
    end
    n_tests++;
    if (res_seen !== result || early) begin
      n_fail++; $display("FAIL cls_res: res=%b early=%b want %b/0", res_seen, early, result);
    end
    @(negedge clk);
    n_tests++;
    if ({res_valid, res} !== {1'b0, result}) begin
      n_fail++; $display("FAIL cls_pulse: res_valid/res=%b want 0%b", {res_valid, res}, result);
    end
    m_preheld = 1'b0;
  endtask

  task automatic test_done_preheld();
    test_classify(20, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      test_classify($urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_tests++;
    if (overlap != 0) begin
      n_fail++; $display("FAIL start_write_overlap: %0d cycles want 0", overlap);
    end
  endtask

  task automatic test_load_during_wait();
    bit got_res = 1'b0;
    bit res_seen = 1'b0;
    m_delay = 40; m_result = 1'b1; m_preheld = 1'b0; done_raised = 1'b0;
    pulse_cls();
    repeat (3) @(posedge clk);
    pulse_load();
    pulse_cls();
    @(negedge clk);
    n_tests++;
    if ({cls_err, nn_start} !== 2'b10) begin
      n_fail++; $display("FAIL err_wait: cls_err/nn_start=%b want 10", {cls_err, nn_start});
    end
    for (int cyc = 0; cyc < 200 && !got_res; cyc++) begin
      @(negedge clk);
      if (res_valid) begin got_res = 1'b1; res_seen = res; end
    end
    n_tests++;
    if (!got_res || res_seen !== 1'b1) begin
      n_fail++; $display("FAIL wait_load_res: delivered=%b res=%b want 1/1", got_res, res_seen);
    end
    @(negedge clk);
    n_tests++;
    if ({loaded, wt_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wait_load_enter: loaded/ready=%b want 01", {loaded, wt_ready});
    end
  endtask

  task automatic test_cls_err();
    bit ok;
    test_reset();
    pulse_cls();
    @(negedge clk);
    n_tests++;
    if ({cls_err, nn_start, wt_ready} !== 3'b100) begin
      n_fail++; $display("FAIL err_idle: cls_err/nn_start/ready=%b want 100", {cls_err, nn_start, wt_ready});
    end
    @(negedge clk);
    n_tests++;
    if (cls_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: cls_err=%b want 0", cls_err);
    end
    pulse_load();
    sent.delete();
    stream_words(10, 0, 1'b1, ok);
    pulse_cls();
    @(negedge clk);
    n_tests++;
    if ({cls_err, nn_start, loaded} !== 3'b100) begin
      n_fail++; $display("FAIL err_load: cls_err/nn_start/loaded=%b want 100", {cls_err, nn_start, loaded});
    end
    test_load(2, 1'b1);
    @(posedge clk); #1 cls_req = 1'b1; load_req = 1'b1;
    @(posedge clk); #1 cls_req = 1'b0; load_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cls_err, nn_start, loaded, wt_ready} !== 4'b1001) begin
      n_fail++; $display("FAIL err_both: cls_err/nn_start/loaded/ready=%b want 1001",
                         {cls_err, nn_start, loaded, wt_ready});
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    sent.delete();
    pulse_load();
    stream_words(600, 2, 1'b1, ok);
    n_tests++;
    if (!ok || loaded !== 1'b0) begin
      n_fail++; $display("FAIL midload_state: streamed=%b loaded=%b want 1/0", ok, loaded);
    end
    test_reset();
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; cls_req = 1'b0; wt_valid = 1'b0; wt_data = '0;
    test_reset();
    test_load_index();
    test_classify(50, 1'b1, 1'b0);
    test_done_preheld();
    test_back_to_back();
    test_load_during_wait();
    test_load_stall();
    test_cls_err();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/det_nn_ctrl.md
Name: det_nn_ctrl

Overview:
Sequencer in front of det_nn. Accepts the 1257-word detector weight image as a valid/ready stream and walks the layer/neuron/weight indices to drive det_nn's weight-write port. Once loading is complete, it arbitrates classify requests: it pulses det_nn start, waits for det_nn done, and returns the 1-bit result to the host.

Parameters:
WORD_W, 64, width of weight words and weight_bus
NUM_LAYERS, 7, number of det_nn layers; sizes are fixed internal tables (neurons 4,16,5,1,1,1,1; inputs 100,25,80,4,16,5,3)
TOTAL_WORDS, 1257, sum over layers of neurons*(inputs+1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_req  in  1  1-cycle pulse: begin or restart the weight load
wt_valid  in  1  weight word valid
wt_data  in  WORD_W  weight word
wt_ready  out  1  weight word accepted when wt_valid&&wt_ready
loaded  out  1  full weight set resident in det_nn
cls_req  in  1  1-cycle pulse: classify current data_in
cls_busy  out  1  classification in flight
res_valid  out  1  1-cycle pulse, res valid
res  out  1  latched det_nn result
cls_err  out  1  1-cycle pulse: cls_req rejected
nn_write_weight  out  1  to det_nn write_weight
nn_layer_sel  out  3  to det_nn layer_sel
nn_neuron_sel  out  4  to det_nn neuron_sel
nn_weight_sel  out  7  to det_nn weight_sel (0 = bias, k+1 = input k)
nn_weight_bus  out  WORD_W  to det_nn weight_bus
nn_start  out  1  to det_nn start
nn_done  in  1  from det_nn done
nn_result  in  1  from det_nn result

Behaviour:
- One clock domain and a synchronous active-high reset.
- Reset values: state=IDLE, loaded=0, wt_ready=0, cls_busy=0, res_valid=0, res=0, cls_err=0, nn_write_weight=0, nn_start=0, all selects=0, nn_weight_bus=0, index counters=0.
- States: IDLE, LOAD, READY, START, WAIT.
- IDLE: on load_req go to LOAD; on cls_req pulse cls_err.
- LOAD: wt_ready=1 combinationally from the state. Each accepted word is registered onto nn_weight_bus/selects with nn_write_weight=1 on the next cycle (latency 1). When wt_valid=0, nn_write_weight=0 and no index advance.
- Index walk: weight_sel 0..inputs[layer]; then neuron+1 and weight_sel=0; after the last neuron, layer+1 and neuron=0.
- The 1257th accepted word moves the FSM to READY, with loaded=1 from the cycle after that word's nn_write_weight.
- In LOAD, cls_req is rejected with cls_err.
- In LOAD, load_req restarts the counters at (0,0,0), and loaded stays 0.
- READY: on cls_req, pulse nn_start for exactly 1 cycle (state START), set cls_busy=1, then go to WAIT.
- READY: load_req clears loaded and enters LOAD.
- If cls_req and load_req arrive in the same cycle, load_req wins and cls_err pulses.
- WAIT: on the first cycle nn_done=1, latch res<=nn_result, pulse res_valid, clear cls_busy, and return to READY.
- WAIT: cls_req gives cls_err. load_req is held pending and serviced on return to READY; the in-flight result is still delivered.
- nn_done already high on entry to WAIT is ignored until it has been seen low once (edge semantics).
- Reset mid-load or mid-classify returns to IDLE and clears loaded. det_nn state is not otherwise touched.
- nn_start and nn_write_weight are never high in the same cycle.

Optional Feature:
- DET_NN_CTRL_CSUM_EN defined: adds output port wt_csum [WORD_W-1:0].
  - Modulo-2^WORD_W sum of all words accepted since the last load_req or reset.
  - Cleared on load_req and on reset.
  - Frozen once loaded=1.
- Not defined: no port and no adder; behaviour is otherwise identical.

Test Plan:
- Reset, load_req, then stream 1257 words with value = index, no stalls -> write 0 is (0,0,0)=0; write 101 is (0,1,0)=101; write 403 is (0,3,100)=403; write 404 is (1,0,0)=404; last write is (6,0,3)=1256; loaded=1; wt_ready=0 afterwards.
- Same stream with wt_valid deasserted every third cycle -> identical select/data sequence; no duplicate or skipped write.
- Load done, cls_req, det_nn model raises nn_done 50 cycles later with nn_result=1 -> single-cycle nn_start; cls_busy for the duration; res_valid pulse; res=1.
- cls_req in IDLE, in LOAD, and in WAIT -> cls_err pulse each time; no nn_start.
- load_req during WAIT -> result still delivered, then LOAD entered with loaded=0; rst asserted at word 600 -> all outputs return to reset values.
- DET_NN_CTRL_CSUM_EN with words = index -> wt_csum = 789,396 (sum 0..1256) after loaded.
